// File: rtl/sensor_input_conditioner_pkg.sv
// Shared constants for the sensor input conditioner: channel indices and settle FSM encodings.
package sensor_input_conditioner_pkg;

  localparam int unsigned NUM_CH    = 7;
  localparam int unsigned CH_HIGH   = 0;
  localparam int unsigned CH_MIDDLE = 1;
  localparam int unsigned CH_LOW    = 2;
  localparam int unsigned CH_SOIL   = 3;
  localparam int unsigned CH_AIR    = 4;
  localparam int unsigned CH_TEMP   = 5;
  localparam int unsigned CH_SEL    = 6;

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/sensor_input_conditioner_if.sv
// Pin-side bundle: raw board inputs in, debounced sensor levels and status out.
interface sensor_input_conditioner_if;

  logic high_raw;
  logic middle_raw;
  logic low_raw;
  logic soil_raw;
  logic air_raw;
  logic temp_raw;
  logic seletor_raw;

  logic high;
  logic middle;
  logic low;
  logic umidadeDoSolo;
  logic umidadeDoAr;
  logic temperatura;
  logic seletor;
  logic changed;
  logic settled;

  modport master (
    output high_raw, middle_raw, low_raw, soil_raw, air_raw, temp_raw, seletor_raw,
    input  high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura, seletor,
    input  changed, settled
  );

  modport slave (
    input  high_raw, middle_raw, low_raw, soil_raw, air_raw, temp_raw, seletor_raw,
    output high, middle, low, umidadeDoSolo, umidadeDoAr, temperatura, seletor,
    output changed, settled
  );

endinterface

// File: rtl/sensor_input_conditioner_debounce_cell.sv
// One channel: 2-flop synchroniser, hold counter and stable output register.
// toggle is high in the cycle the stable output takes a new value.
module debounce_cell #(
  parameter  int unsigned DEBOUNCE_CYCLES = 500000,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 3)
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic dout,
  output logic toggle
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // A disagreeing sample must persist for DEBOUNCE_CYCLES cycles; agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      dout   <= 1'b0;
      toggle <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= din_raw;
      sync2  <= sync1;
      toggle <= 1'b0;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_TERM) begin
        dout   <= sync2;
        toggle <= 1'b1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_input_conditioner.sv
// Sensor front end: seven debounced channels, a post-reset settle window and a change strobe.
module sensor_input_conditioner
  import sensor_input_conditioner_pkg::*;
#(
  parameter  int unsigned DEBOUNCE_CYCLES = 500000,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 3)
) (
  input  logic                        clk,
  input  logic                        reset,
  sensor_input_conditioner_if.slave   bus
);

  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(DEBOUNCE_CYCLES + 1);

  ch_vec_t          raw;
  ch_vec_t          q;
  ch_vec_t          tgl;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] settle_cnt_nxt;

  assign raw[CH_HIGH]   = bus.high_raw;
  assign raw[CH_MIDDLE] = bus.middle_raw;
  assign raw[CH_LOW]    = bus.low_raw;
  assign raw[CH_SOIL]   = bus.soil_raw;
  assign raw[CH_AIR]    = bus.air_raw;
  assign raw[CH_TEMP]   = bus.temp_raw;
  assign raw[CH_SEL]    = bus.seletor_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .din_raw(raw[i]),
      .dout   (q[i]),
      .toggle (tgl[i])
    );
  end

  assign bus.high          = q[CH_HIGH];
  assign bus.middle        = q[CH_MIDDLE];
  assign bus.low           = q[CH_LOW];
  assign bus.umidadeDoSolo = q[CH_SOIL];
  assign bus.umidadeDoAr   = q[CH_AIR];
  assign bus.temperatura   = q[CH_TEMP];
  assign bus.seletor       = q[CH_SEL];

  // Settle window state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
    end
  end

  // Settle window lasts DEBOUNCE_CYCLES+2 edges so the synchronisers and first debounce can flush
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    case (state)
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_TERM) begin
          state_nxt      = ST_RUN;
          settle_cnt_nxt = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        settle_cnt_nxt = '0;
      end
    endcase
  end

  // Both terms are flop outputs, so the strobe lines up with the output update cycle
  assign bus.settled = (state == ST_RUN);
  assign bus.changed = bus.settled & (|tgl);

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: directed scenarios with literal expectations plus
// randomized pin activity compared every cycle against a sample-window reference model.
module tb_sensor_input_conditioner;
  import sensor_input_conditioner_pkg::*;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] raw;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  sensor_input_conditioner_if bus ();

  sensor_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.high_raw    = raw[CH_HIGH];
  assign bus.middle_raw  = raw[CH_MIDDLE];
  assign bus.low_raw     = raw[CH_LOW];
  assign bus.soil_raw    = raw[CH_SOIL];
  assign bus.air_raw     = raw[CH_AIR];
  assign bus.temp_raw    = raw[CH_TEMP];
  assign bus.seletor_raw = raw[CH_SEL];

  assign outs = {bus.seletor, bus.temperatura, bus.umidadeDoAr, bus.umidadeDoSolo,
                 bus.low, bus.middle, bus.high};

  // Reference model: keeps the raw samples of recent edges. A channel flips when the
  // synchronised samples seen over the last DEB edges all disagree with its current value.
  logic [6:0] hist [0:DEB+1];
  logic [6:0] m_q;
  logic       m_changed;
  logic       m_settled;
  logic       m_valid = 1'b0;
  int         m_edges;

  always @(posedge clk) begin
    logic [6:0] flip;
    logic       all_diff;
    if (reset) begin
      for (int k = 0; k <= DEB + 1; k++) hist[k] = '0;
      m_q       = '0;
      m_changed = 1'b0;
      m_settled = 1'b0;
      m_edges   = 0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      flip = '0;
      for (int ch = 0; ch < 7; ch++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (hist[k][ch] == m_q[ch]) all_diff = 1'b0;
        flip[ch] = all_diff;
      end
      m_q       = m_q ^ flip;
      m_edges   = m_edges + 1;
      m_settled = (m_edges >= DEB + 2);
      m_changed = (flip != '0) && m_settled;
      for (int k = DEB + 1; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = raw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then compare every output against the model
  task automatic step();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("model_outs", 32'(outs), 32'(m_q));
      chk("model_changed", 32'(bus.changed), 32'(m_changed));
      chk("model_settled", 32'(bus.settled), 32'(m_settled));
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    raw   = '1;
    steps(3);
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_changed", 32'(bus.changed), 32'd0);
    chk("reset_settled", 32'(bus.settled), 32'd0);
    reset = 1'b0;
    step();
    chk("post_reset_outs", 32'(outs), 32'd0);

    // Settle window from a fresh reset with quiet pins
    raw   = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("settle_flag", 32'(bus.settled), 32'(i == 6));
      chk("settle_changed", 32'(bus.changed), 32'd0);
    end
    steps(2);

    // Clean edge
    raw[CH_LOW] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("clean_low", 32'(bus.low), 32'(i == 6));
      chk("clean_changed", 32'(bus.changed), 32'(i == 6));
    end
    step();
    chk("clean_strobe_end", 32'(bus.changed), 32'd0);
    chk("clean_outs", 32'(outs), 32'h04);

    // Glitch shorter than the debounce window
    raw[CH_SOIL] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) raw[CH_SOIL] = 1'b0;
      step();
      chk("glitch_soil", 32'(bus.umidadeDoSolo), 32'd0);
      chk("glitch_changed", 32'(bus.changed), 32'd0);
    end

    // Bounce before settling high
    raw[CH_HIGH] = 1'b1;
    step();
    raw[CH_HIGH] = 1'b0;
    step();
    raw[CH_HIGH] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("bounce_high", 32'(bus.high), 32'(i == 6));
    end

    // Simultaneous edges on two channels
    raw[CH_MIDDLE] = 1'b1;
    raw[CH_TEMP]   = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("simul_middle", 32'(bus.middle), 32'(i == 6));
      chk("simul_temp", 32'(bus.temperatura), 32'(i == 6));
      chk("simul_changed", 32'(bus.changed), 32'(i == 6));
    end
    step();
    chk("simul_strobe_end", 32'(bus.changed), 32'd0);

    // Mid-count reset discards the partial count
    raw[CH_MIDDLE] = 1'b0;
    raw[CH_TEMP]   = 1'b0;
    steps(8);
    raw[CH_MIDDLE] = 1'b1;
    raw[CH_TEMP]   = 1'b1;
    steps(3);
    reset = 1'b1;
    step();
    chk("midreset_outs", 32'(outs), 32'd0);
    chk("midreset_settled", 32'(bus.settled), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("midreset_middle", 32'(bus.middle), 32'(i == 6));
    end

    // Randomized pin activity with occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int ch = 0; ch < 7; ch++)
        if ($urandom_range(0, 5) == 0) raw[ch] = ~raw[ch];
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    steps(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
